uart_rx_frame_receiver: RTL
===========================

// Module: uart_rx_frame_receiver
// PURPOSE
// - UART receive stage: consumes the serial frame produced by the TX serializer (start, DATA_WIDTH LSB-first data bits, optional parity, one stop bit).
// - Oversamples the line at i_prescale clocks per bit and majority-votes 3 samples per bit.
// - Checks parity and stop, then presents a parallel word with a 1-cycle valid pulse to downstream logic.
// PARAMETERS
// - DATA_WIDTH  8  data bits per frame
// - PRESC_W     6  width of i_prescale (max 63 clocks/bit)
// PORTS
// - i_clk            in   1           clock
// - i_rst            in   1           asynchronous, active-low reset
// - i_rx_in          in   1           serial line, idle high, asynchronous to i_clk
// - i_prescale       in   PRESC_W     clocks per bit; legal values are even, 8..62
// - i_parity_enable  in   1           1 = frame carries a parity bit
// - i_parity_type    in   1           0 = even, 1 = odd
// - o_data           out  DATA_WIDTH  last good word; held until next good word
// - o_data_valid     out  1           1-cycle pulse, o_data updated same cycle
// - o_parity_error   out  1           1-cycle pulse, frame dropped
// - o_stop_error     out  1           1-cycle pulse, frame dropped
// - o_busy           out  1           high in every state except IDLE
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 1.
// - i_rx_in passes through a 2-FF synchronizer (rx_s); all decisions use rx_s. Line-to-rx_s latency is 2 cycles.
// - Config latch: i_prescale, i_parity_enable and i_parity_type are captured on IDLE->START. Changes mid-frame have no effect.
// - Edge counter runs 0..P-1 per bit (P = latched prescale) and wraps to 0 at each bit boundary.
// - Sample points are counts M-1, M and M+1 (M = P/2). Bit value = majority of the 3 samples, resolved at count M+1.
// - States: IDLE, START, DATA, PARITY, STOP.
// - IDLE: first cycle with rx_s=0 -> START; edge counter = 0 in that cycle.
// - START: resolved majority 1 = glitch -> IDLE, no outputs. Majority 0 -> DATA at count wrap.
// - DATA: bits shift in LSB first. Bit counter 0..DATA_WIDTH-1.
//   - Last bit wrap -> PARITY if enabled, else STOP.
// - PARITY: compare the received bit with ^data ^ parity_type. Mismatch sets a sticky par_err flag. -> STOP at wrap.
// - STOP: at resolution (count M+1), registered results appear on the next cycle:
//   - stop=1 and !par_err: o_data<=word, o_data_valid=1.
//   - par_err: o_parity_error=1.
//   - stop=0: o_stop_error=1 (both errors may pulse together).
//   - Then -> IDLE directly; the rest of the stop bit is not waited out, so the next start edge is caught.
// - Latency: outputs pulse on cycle S*P + M + 2 after start detection (S = DATA_WIDTH+1, or +2 with parity).
//   - Example, P=8, no parity: cycle 78.
// - Line held low (break): stop error reported, then IDLE re-detects the low line as a new start on the next cycle.
// - Async reset mid-frame: immediate return to reset values; no partial word or pulse is emitted.
// STRUCTURE
// - Shared package/include: state encodings, PARITY_EVEN/PARITY_ODD constants, DATA_WIDTH default.
// - Sub-module uart_rx_bit_sampler: edge counter, 3-point majority vote, bit_done/bit_value strobes.
// - Top level: FSM, shift register, bit counter, parity/stop check, output registers.
// TESTING
// - P=8, parity off, send 0xA5: o_data=0xA5 and o_data_valid high 1 cycle at detect+78; o_busy low afterwards.
// - P=16, even parity, send 0x3C, parity bit 0: valid, o_data=0x3C. Resend with parity bit 1: o_parity_error pulse, no valid, o_data stays 0x3C.
// - P=16, send 0x81 with stop bit 0: o_stop_error pulse, no valid.
// - Glitch: rx low for 3 clocks at P=16: back to IDLE with no pulses; o_busy high only during START.
// - P=32, odd parity, 0x00 then 0xFF back-to-back (next start right after stop): two valid pulses, parity bits 1 and 1.
// - Assert i_rst mid-DATA: outputs 0 at once. After release, 0x5A is received correctly; a prescale change mid-frame is ignored.

Source files
------------

// File: rtl/uart_rx_frame_receiver_pkg.sv
// rtl/uart_rx_frame_receiver_pkg.sv - shared types and constants for the UART receive stage
package uart_rx_frame_receiver_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESC_W_DEF    = 6;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // 2-of-3 majority used to resolve each oversampled bit
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frame_receiver_if.sv
// rtl/uart_rx_frame_receiver_if.sv - parallel result bundle from the UART receiver to downstream logic
interface uart_rx_frame_receiver_if
  import uart_rx_frame_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_parity_error;
  logic                  o_stop_error;
  logic                  o_busy;

  modport master (
    output o_data,
    output o_data_valid,
    output o_parity_error,
    output o_stop_error,
    output o_busy
  );

  modport slave (
    input o_data,
    input o_data_valid,
    input o_parity_error,
    input o_stop_error,
    input o_busy
  );

endinterface

// File: rtl/uart_rx_bit_sampler.sv
// rtl/uart_rx_bit_sampler.sv - per-bit edge counter with 3-point majority vote around mid-bit
module uart_rx_bit_sampler
  import uart_rx_frame_receiver_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr_i,
  input  logic               i_rx_s_i,
  input  logic [PRESC_W-1:0] i_prescale_i,
  output logic               o_bit_done_o,
  output logic               o_bit_value_o,
  output logic               o_bit_end_o
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] half;
  logic               s0_q, s1_q;

  assign half          = {1'b0, i_prescale_i[PRESC_W-1:1]};
  assign o_bit_end_o   = (cnt_q == i_prescale_i - ONE);
  assign o_bit_done_o  = (cnt_q == half + ONE);
  // Third sample is taken live at resolution time, so the vote is ready that same cycle
  assign o_bit_value_o = maj3(s0_q, s1_q, i_rx_s_i);

  // Counter restarts at every bit boundary and is held at 0 whenever the FSM is heading to IDLE
  always_comb begin
    cnt_d = cnt_q + ONE;
    if (i_clr_i || o_bit_end_o) begin
      cnt_d = '0;
    end
  end

  // Edge counter and the two early samples (counts M-1 and M)
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == half - ONE) s0_q <= i_rx_s_i;
      if (cnt_q == half)       s1_q <= i_rx_s_i;
    end
  end

endmodule

// File: rtl/uart_rx_frame_receiver.sv
// rtl/uart_rx_frame_receiver.sv - UART receive stage: frame FSM, parity/stop check, parallel output
module uart_rx_frame_receiver
  import uart_rx_frame_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESC_W    = PRESC_W_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_rx_in,
  input  logic [PRESC_W-1:0]           i_prescale,
  input  logic                         i_parity_enable,
  input  logic                         i_parity_type,
  uart_rx_frame_receiver_if.master     rx_if_o
);

  localparam int BC_W = $clog2(DATA_WIDTH);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_WIDTH - 1);
  localparam logic [BC_W-1:0] BIT_ONE  = BC_W'(1);

  logic                  rx_meta_q, rx_s_q;
  rx_state_e             state_q, state_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_err_q, par_err_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;

  logic bit_done, bit_value, bit_end, samp_clr;

  // Counter is cleared whenever the FSM will sit in IDLE, so the detect cycle is count 0
  assign samp_clr = (state_d == ST_IDLE);

  uart_rx_bit_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr_i       (samp_clr),
    .i_rx_s_i      (rx_s_q),
    .i_prescale_i  (presc_q),
    .o_bit_done_o  (bit_done),
    .o_bit_value_o (bit_value),
    .o_bit_end_o   (bit_end)
  );

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM: config latch, data shift, parity/stop evaluation and result strobes
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_err_d  = par_err_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d    = ST_START;
          presc_d    = i_prescale;
          par_en_d   = i_parity_enable;
          par_type_d = i_parity_type;
          par_err_d  = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      ST_START: begin
        if (bit_done && bit_value) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = {bit_value, shift_q[DATA_WIDTH-1:1]};
        end
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done && (bit_value != ((^shift_q) ^ (par_type_q == PARITY_ODD)))) begin
          par_err_d = 1'b1;
        end
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave as soon as the stop bit is resolved so an immediately following start is caught
        if (bit_done) begin
          state_d = ST_IDLE;
          perr_d  = par_err_q;
          serr_d  = !bit_value;
          if (bit_value && !par_err_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched configuration, datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PARITY_EVEN;
      par_err_q  <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_err_q  <= par_err_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign rx_if_o.o_data         = data_q;
  assign rx_if_o.o_data_valid   = valid_q;
  assign rx_if_o.o_parity_error = perr_q;
  assign rx_if_o.o_stop_error   = serr_q;
  assign rx_if_o.o_busy         = (state_q != ST_IDLE);

endmodule
